instruction_fetch: RTL and testbench

Fetch stage that supplies instruction words, and their opcode fields, to the control unit's main decoder. It holds the fetch PC and issues word requests to instruction memory over a request/response interface. Responses are buffered and presented downstream with a valid/ready handshake. It accepts branch redirects from the datapath, and flushes or discards wrong-path instructions in flight.

---
 rtl/ifu_pkg.sv | 33 +++
 rtl/ifu_buffer.sv | 72 +++++++
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Build option IFU_PREFETCH_EN: when defined the fetch buffer is two entries
// deep and fetch runs ahead of a stalled decoder; otherwise one entry.
package ifu_pkg;

`ifdef IFU_PREFETCH_EN
  localparam int unsigned IFU_DEPTH = 2;
`else
  localparam int unsigned IFU_DEPTH = 1;
`endif

  // Width of occupancy / outstanding / kill counters (must hold IFU_DEPTH).
  localparam int unsigned IFU_CNT_W = $clog2(IFU_DEPTH + 1);

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  // Main-decoder opcode field values.
  localparam logic [5:0] R_FORMAT = 6'b000000;
  localparam logic [5:0] LW       = 6'b100011;
  localparam logic [5:0] SW       = 6'b101011;
  localparam logic [5:0] BEQ      = 6'b000100;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_buffer.sv
// Small synchronous FIFO of {pc, word} fetch results. The head always sits in
// entry 0 (shift on pop), so the head outputs come straight from registers.
module ifu_buffer
  import ifu_pkg::*;
#(
  parameter  int unsigned DEPTH = IFU_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [31:0]      push_pc_i,
  input  logic [31:0]      push_word_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [31:0]      head_pc_o,
  output logic [31:0]      head_word_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ifu_entry_t       mem_q [DEPTH];
  ifu_entry_t       mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next contents: clear wins; otherwise pop shifts down, then push appends.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else begin
      if (pop_i && (cnt_q != '0)) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          mem_d[i] = mem_q[i+1];
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (push_i && (cnt_q != FULL_CNT)) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i == 32'(cnt_d)) begin
            mem_d[i] = '{pc: push_pc_i, word: push_word_i};
          end
        end
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign head_pc_o   = mem_q[0].pc;
  assign head_word_o = mem_q[0].word;
  assign full_o      = (cnt_q == FULL_CNT);
  assign empty_o     = (cnt_q == '0);
  assign count_o     = cnt_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues word requests to instruction memory under a credit limit,
// buffers responses and presents them to the main decoder with valid/ready.
// Redirects clear the buffer and discard responses still in flight.
// Build option IFU_PREFETCH_EN selects a 2-deep buffer (see ifu_pkg).
module instruction_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  Opcode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  localparam int unsigned DEPTH = IFU_DEPTH;
  localparam int unsigned CW    = IFU_CNT_W;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        outst_q, outst_d;
  cnt_t        kill_q, kill_d;
  logic        live_q;
  ifu_state_e  state_q, state_d;

  cnt_t        occ;
  logic        buf_full, buf_empty;
  logic [31:0] head_pc, head_word;
  logic        accept, pop, push, drop_rsp;
  logic [31:0] rsp_pc;

  assign accept = imem_req && imem_ready;
  assign pop    = instr_valid && instr_ready;
  // Responses return in order, so once nothing is being killed the oldest
  // outstanding request's PC sits outst_q words behind fetch_pc.
  assign rsp_pc = fetch_pc_q - 32'({outst_q, 2'b00});
  assign push   = imem_rvalid && !drop_rsp && !redirect && !buf_full;

  // Credit from registered occupancy + outstanding only; live_q holds it low in reset.
  assign imem_req  = live_q && ((sum_t'(occ) + sum_t'(outst_q)) < sum_t'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // Next fetch PC, outstanding count and kill count.
  always_comb begin
    outst_d = outst_q;
    if (accept) begin
      outst_d = outst_d + cnt_t'(1);
    end
    if (imem_rvalid) begin
      outst_d = outst_d - cnt_t'(1);
    end

    kill_d = kill_q;
    if (redirect) begin
      kill_d = outst_d;
    end else if (imem_rvalid && drop_rsp) begin
      kill_d = kill_q - cnt_t'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_target & ~32'h3;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // Fetch PC and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      kill_q     <= '0;
      live_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
      live_q     <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: drain while wrong-path responses remain to be discarded.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (redirect && (kill_d != '0)) state_d = DRAIN;
      DRAIN:   if (kill_d == '0)               state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: responses arriving while draining are discarded.
  always_comb begin
    drop_rsp = 1'b0;
    unique case (state_q)
      RUN:     drop_rsp = 1'b0;
      DRAIN:   drop_rsp = 1'b1;
      default: drop_rsp = 1'b0;
    endcase
  end

  ifu_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_pc_i   (rsp_pc),
    .push_word_i (imem_rdata),
    .pop_i       (pop),
    .clear_i     (redirect),
    .head_pc_o   (head_pc),
    .head_word_o (head_word),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (occ)
  );

  assign instr_valid = !buf_empty;
  assign instr       = head_word;
  assign Opcode      = head_word[31:26];
  assign pc_out      = head_pc;
  assign pc_plus4    = head_pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a behavioural memory with random
// ready/latency and a program-order model of the expected instruction stream.
`timescale 1ns/1ps
module tb_instruction_fetch;
  import ifu_pkg::*;

  localparam int unsigned DEPTH = IFU_DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  Opcode;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .Opcode          (Opcode),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        pend[$];
  int unsigned cyc;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned accepts;
  int unsigned pops;
  logic [31:0] exp_pc;
  int unsigned lat_min, lat_max, rdy_pct, dec_pct;
  bit          chk_addr, chk_req, chk_invalid;
  logic [31:0] nxt_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check deferred expectations, check any pop against program
  // order, play the memory, drive inputs, advance to the next negedge.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit force_pop);
    bit          rdy, acc, rv, pp;
    logic [31:0] rdat, w;
    if (chk_invalid) check_eq("redir_valid_low", 32'(instr_valid), 32'd0);
    if (chk_addr)    check_eq("next_addr", imem_addr, nxt_addr);
    if (chk_req)     check_eq("req_held", 32'(imem_req), 32'd1);
    chk_invalid = 0; chk_addr = 0; chk_req = 0;

    if (imem_req) check_eq("credit", 32'(pend.size() < DEPTH), 32'd1);

    rv   = (pend.size() > 0) && (pend[0].due <= cyc);
    rdat = rv ? mem_word(pend[0].addr) : $urandom;
    rdy  = ($urandom_range(99) < rdy_pct);
    acc  = imem_req && rdy;
    pp   = instr_valid && (force_pop || ($urandom_range(99) < dec_pct));

    if (pp) begin
      w = mem_word(exp_pc);
      check_eq("instr", instr, w);
      check_eq("pc_out", pc_out, exp_pc);
      check_eq("pc_plus4", pc_plus4, exp_pc + 32'd4);
      check_eq("opcode", 32'(Opcode), 32'(w[31:26]));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (acc) begin
      pend.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      accepts++;
    end
    if (rv) void'(pend.pop_front());

    if (redir) begin
      exp_pc = tgt & ~32'h3;
      chk_invalid = 1; chk_addr = 1; nxt_addr = tgt & ~32'h3;
    end else if (acc) begin
      chk_addr = 1; nxt_addr = imem_addr + 32'd4;
    end else if (imem_req) begin
      chk_req = 1; chk_addr = 1; nxt_addr = imem_addr;
    end

    imem_ready      = rdy;
    imem_rvalid     = rv;
    imem_rdata      = rdat;
    instr_ready     = instr_valid ? pp : 1'($urandom_range(1));
    redirect        = redir;
    redirect_target = tgt;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic run_until_pops(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (pops < target && n < budget) begin
      step(0, 32'h0, 0);
      n++;
    end
    check_eq(tag, 32'(pops >= target), 32'd1);
  endtask

  initial begin
    bit found;
    int unsigned n;

    reset = 1'b1; imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    instr_ready = 0; redirect = 0; redirect_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_opcode", 32'(Opcode), 32'd0);
    check_eq("rst_pc_out", pc_out, 32'h0);
    check_eq("rst_pc_plus4", pc_plus4, 32'h4);
    pend.delete(); chk_addr = 0; chk_req = 0; chk_invalid = 0;
    exp_pc = 32'h0; cyc = 0; accepts = 0; pops = 0;
    reset = 1'b0;

    // First-fetch latency, then decoder stall: fill to the credit limit and stop.
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 0) check_eq("first_req_low", 32'(imem_req), 32'd0);
      if (k == 1) check_eq("first_req_high", 32'(imem_req), 32'd1);
      if (k <= 3) check_eq("first_valid", 32'(instr_valid), 32'(k == 3));
      if (k == 3) begin
        check_eq("first_opcode", 32'(Opcode), 32'(LW));
        check_eq("first_pc_out", pc_out, 32'h0);
        check_eq("first_pc_plus4", pc_plus4, 32'h4);
      end
      step(0, 32'h0, 0);
    end
    check_eq("stall_accepts", accepts, DEPTH);
    check_eq("stall_req_low", 32'(imem_req), 32'd0);
    dec_pct = 100;
    run_until_pops("stall_release", 6, 200);

    // Redirect with the credit limit's worth of requests outstanding.
    lat_min = 4; lat_max = 4;
    n = 0;
    while (pend.size() < DEPTH && n < 100) begin step(0, 32'h0, 0); n++; end
    check_eq("outstanding_full", pend.size(), DEPTH);
    step(1, 32'h0000_0041, 0);
    run_until_pops("redir_resume", pops + 3, 200);

    // Redirect coinciding with a response (and a pop when both can coincide).
    lat_min = 1; lat_max = 1;
    found = 0; n = 0;
    while (!found && n < 200) begin
      if ((pend.size() > 0) && (pend[0].due <= cyc) && (instr_valid || DEPTH == 1)) begin
        step(1, 32'h0000_0100, 1);
        found = 1;
      end else begin
        step(0, 32'h0, 0);
      end
      n++;
    end
    check_eq("redir_rvalid_found", 32'(found), 32'd1);
    found = 0; n = 0;
    while (!found && n < 200) begin
      if (instr_valid) begin
        step(1, 32'h0000_0200, 1);
        found = 1;
      end else begin
        step(0, 32'h0, 0);
      end
      n++;
    end
    check_eq("redir_pop_found", 32'(found), 32'd1);
    repeat (10) step(0, 32'h0, 0);
    check_eq("kill_zero", 32'(dut.kill_q), 32'd0);
    check_eq("fsm_run", 32'(dut.state_q), 32'(RUN));
    run_until_pops("redir_after_pop", pops + 3, 200);

    // Address wrap at the top of memory.
    step(1, 32'hFFFF_FFFC, 0);
    run_until_pops("wrap", pops + 3, 200);

    // Random ready, latency 1..4 and decoder back-pressure, no redirects.
    lat_min = 1; lat_max = 4; rdy_pct = 60; dec_pct = 70;
    run_until_pops("random_stream", pops + 500, 20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
